mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the processor's data-memory port and the data RAM. Decodes the data address and steers each access either to RAM or to a bank of debounced, edge-latching button inputs and writable output registers. Returns read data on the same one-cycle latency as the RAM. Replaces the fixed single-button / single-output address decode in the top-level wrapper.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_debounce.sv | 56 +++++
 rtl/mmio_bridge.sv | 155 +++++++++++++++
 tb/tb_mmio_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO bridge.
//   - status-word bit positions for input channel reads
//   - default base addresses and debounce length
//   - maximum channel count, used to size zero-padded lookup vectors
//   - addr_in_range(): half-open word-address range test
package mmio_pkg;

    localparam int ST_LVL  = 0;
    localparam int ST_EVT  = 1;
    localparam int W1C_BIT = 1;

    localparam int MAX_CH = 16;

    localparam logic [31:0] DEF_IN_BASE   = 32'd1000;
    localparam logic [31:0] DEF_OUT_BASE  = 32'd2000;
    localparam logic [15:0] DEF_DB_CYCLES = 16'd1000;

    // True when base <= addr < base + n. The subtraction form avoids
    // overflow when base + n would wrap past 2^32.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned n);
        return (addr >= base) && ((addr - base) < 32'(n));
    endfunction

endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: one button channel.
//   clock, reset : clock and synchronous active-high reset
//   btn_raw      : asynchronous raw button input
//   lvl          : debounced stable level
//   rise         : one-cycle pulse, high in the cycle whose edge raises lvl
module mmio_debounce
    import mmio_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic lvl,
    output logic rise
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        lvl_q, lvl_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == DB_CYCLES - 16'd1) begin
                lvl_d = ~lvl_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl = lvl_q;
    // Taken from the next-state so the sticky event latches on the same edge
    // that raises lvl; a status read then never sees lvl=1 with evt=0.
    assign rise = lvl_d & ~lvl_q;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: steers processor data accesses to RAM or to MMIO registers.
//   address_dmem, wren, data : processor data-memory request
//   q_dmem                   : read data, one cycle after the address
//   ram_q, ram_wren          : RAM read data in, gated RAM write enable out
//   button_in                : raw buttons, one debounced channel each
//   processor_out            : output registers, channel j at [32j+31:32j]
//   irq                      : present only when MMIO_IRQ_EN is defined
// Build option MMIO_IRQ_EN adds a mask register at IN_BASE+NUM_IN and a
// registered interrupt |(evt & mask).
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          NUM_IN    = 4,
    parameter int          NUM_OUT   = 4,
    parameter logic [31:0] IN_BASE   = DEF_IN_BASE,
    parameter logic [31:0] OUT_BASE  = DEF_OUT_BASE,
    parameter logic [15:0] DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            address_dmem,
    input  logic                   wren,
    input  logic [31:0]            data,
    output logic [31:0]            q_dmem,
    input  logic [31:0]            ram_q,
    output logic                   ram_wren,
    input  logic [NUM_IN-1:0]      button_in,
    output logic [NUM_OUT*32-1:0]  processor_out
`ifdef MMIO_IRQ_EN
    ,
    output logic                   irq
`endif
);

    logic              in_chan_hit, mask_hit, in_hit, out_hit, hit;
    logic [3:0]        in_idx, out_idx;
    logic [NUM_IN-1:0] lvl, rise;
    logic [NUM_IN-1:0] evt_q, evt_d;
    logic [MAX_CH-1:0] lvl_pad, evt_pad;
    logic [31:0]       out_q [NUM_OUT];
    logic [31:0]       out_d [NUM_OUT];
    logic              sel_mmio_q, sel_mmio_d;
    logic [31:0]       mmio_rd_q, mmio_rd_d;

    assign in_chan_hit = addr_in_range(address_dmem, IN_BASE, NUM_IN);
    assign out_hit     = addr_in_range(address_dmem, OUT_BASE, NUM_OUT);
`ifdef MMIO_IRQ_EN
    // Decoded separately: with NUM_IN=16 its 4-bit index would alias channel 0.
    assign mask_hit = (address_dmem == IN_BASE + 32'(NUM_IN));
`else
    assign mask_hit = 1'b0;
`endif
    assign in_hit   = in_chan_hit | mask_hit;
    assign hit      = in_hit | out_hit;
    assign in_idx   = 4'(address_dmem - IN_BASE);
    assign out_idx  = 4'(address_dmem - OUT_BASE);
    assign ram_wren = wren & ~hit;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        mmio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (button_in[i]),
            .lvl     (lvl[i]),
            .rise    (rise[i])
        );
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        assign processor_out[32*j +: 32] = out_q[j];
    end

    // Zero-padded so an out-of-range index reads 0 instead of going past the vector.
    assign lvl_pad = MAX_CH'(lvl);
    assign evt_pad = MAX_CH'(evt_q);

`ifdef MMIO_IRQ_EN
    logic [NUM_IN-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wren && mask_hit) begin
            mask_d = data[NUM_IN-1:0];
        end
        irq_d = |(evt_q & mask_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        // A rising edge in the same cycle as a W1C wins: rise is OR'd in last.
        for (int i = 0; i < NUM_IN; i++) begin
            evt_d[i] = (evt_q[i] & ~(wren & in_chan_hit & data[W1C_BIT]
                                     & (in_idx == 4'(i)))) | rise[i];
        end

        for (int j = 0; j < NUM_OUT; j++) begin
            out_d[j] = out_q[j];
            if (wren && out_hit && (out_idx == 4'(j))) begin
                out_d[j] = data;
            end
        end

        sel_mmio_d = hit;
        mmio_rd_d  = '0;
        if (in_chan_hit) begin
            mmio_rd_d[ST_EVT] = evt_pad[in_idx];
            mmio_rd_d[ST_LVL] = lvl_pad[in_idx];
        end else if (out_hit) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (out_idx == 4'(j)) begin
                    mmio_rd_d = out_q[j];
                end
            end
        end
`ifdef MMIO_IRQ_EN
        else if (mask_hit) begin
            mmio_rd_d = 32'(mask_q);
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            evt_q      <= '0;
            sel_mmio_q <= 1'b0;
            mmio_rd_q  <= '0;
            for (int j = 0; j < NUM_OUT; j++) begin
                out_q[j] <= '0;
            end
        end else begin
            evt_q      <= evt_d;
            sel_mmio_q <= sel_mmio_d;
            mmio_rd_q  <= mmio_rd_d;
            for (int j = 0; j < NUM_OUT; j++) begin
                out_q[j] <= out_d[j];
            end
        end
    end

    assign q_dmem = sel_mmio_q ? mmio_rd_q : ram_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: self-checking bench for mmio_bridge (NUM_IN=4, NUM_OUT=4,
// IN_BASE=1000, OUT_BASE=2000, DB_CYCLES=4). Read expectations are queued
// when the read is issued and popped when q_dmem is valid one edge later.
module tb_mmio_bridge;

    localparam logic [31:0] IN_B  = 32'd1000;
    localparam logic [31:0] OUT_B = 32'd2000;
    localparam int          NI    = 4;
    localparam int          NO    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   address_dmem = 32'd5;
    logic          wren = 1'b0;
    logic [31:0]   data = 32'd0;
    logic [31:0]   q_dmem;
    logic [31:0]   ram_q = 32'd0;
    logic          ram_wren;
    logic [NI-1:0] button_in = '0;
    logic [NO*32-1:0] processor_out;
`ifdef MMIO_IRQ_EN
    logic          irq;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic        rw;

    always #5 clock = ~clock;

    // Stand-in RAM: read data is a fixed pattern of the address, one cycle late.
    always @(posedge clock) ram_q <= {16'hA5A5, address_dmem[15:0]};

    mmio_bridge #(
        .NUM_IN    (NI),
        .NUM_OUT   (NO),
        .IN_BASE   (IN_B),
        .OUT_BASE  (OUT_B),
        .DB_CYCLES (16'd4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address_dmem  (address_dmem),
        .wren          (wren),
        .data          (data),
        .q_dmem        (q_dmem),
        .ram_q         (ram_q),
        .ram_wren      (ram_wren),
        .button_in     (button_in),
        .processor_out (processor_out)
`ifdef MMIO_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    task automatic rd_cycle(input logic [31:0] a);
        address_dmem = a;
        wren = 1'b0;
        data = 32'd0;
        @(posedge clock);
        #1;
    endtask

    task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d, output logic rw_seen);
        address_dmem = a;
        data = d;
        wren = 1'b1;
        #1;
        rw_seen = ram_wren;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        address_dmem = 32'd5;
        wren = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if (q_dmem !== 32'hA5A50005) begin
            n_fail++; $display("FAIL reset_q_is_ram got=%h exp=%h", q_dmem, 32'hA5A50005);
        end
        n_tests++;
        if (processor_out !== '0) begin
            n_fail++; $display("FAIL reset_out got=%h exp=0", processor_out);
        end
        reset = 1'b0;

        exp_q.push_back(32'd0);
        rd_cycle(OUT_B + 32'd2);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL reset_read_out2 got=%h exp=%h", q_dmem, e);
        end

        exp_q.push_back(32'hA5A50005);
        rd_cycle(32'd5);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL ram_read got=%h exp=%h", q_dmem, e);
        end

        wren = 1'b1; #1; n_tests++;
        if (ram_wren !== 1'b1) begin
            n_fail++; $display("FAIL ram_wren_hi got=%b exp=1", ram_wren);
        end
        wren = 1'b0; #1; n_tests++;
        if (ram_wren !== 1'b0) begin
            n_fail++; $display("FAIL ram_wren_lo got=%b exp=0", ram_wren);
        end
    endtask

    task automatic test_out_write();
        logic [31:0] exp_rd [3];
        logic [31:0] rd_addr [3];
        wr_cycle(OUT_B + 32'd1, 32'hDEADBEEF, rw);
        n_tests++;
        if (rw !== 1'b0) begin
            n_fail++; $display("FAIL out_wr_ram_wren got=%b exp=0", rw);
        end
        n_tests++;
        if (processor_out !== {64'h0, 32'hDEADBEEF, 32'h0}) begin
            n_fail++; $display("FAIL out_wr_value got=%h exp=%h", processor_out, {64'h0, 32'hDEADBEEF, 32'h0});
        end
        exp_q.push_back(32'hDEADBEEF);
        rd_cycle(OUT_B + 32'd1);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL out_readback got=%h exp=%h", q_dmem, e);
        end

        wr_cycle(OUT_B + 32'd3, 32'h0BADF00D, rw);
        rd_addr = '{OUT_B + 32'd3, 32'd7, OUT_B + 32'd0};
        exp_rd  = '{32'h0BADF00D, 32'hA5A50007, 32'h0};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(exp_rd[k]);
            rd_cycle(rd_addr[k]);
            e = exp_q.pop_front(); n_tests++;
            if (q_dmem !== e) begin
                n_fail++; $display("FAIL back_to_back_%0d got=%h exp=%h", k, q_dmem, e);
            end
        end
    endtask

    task automatic test_debounce();
        button_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back((k == 7) ? 32'h3 : 32'h0);
            rd_cycle(IN_B);
            e = exp_q.pop_front(); n_tests++;
            if (q_dmem !== e) begin
                n_fail++; $display("FAIL lvl_latency_edge%0d got=%h exp=%h", k, q_dmem, e);
            end
        end
        exp_q.push_back(32'h3);
        rd_cycle(IN_B);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL read_no_side_effect got=%h exp=%h", q_dmem, e);
        end

        button_in[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) button_in[1] = 1'b0;
            exp_q.push_back(32'h0);
            rd_cycle(IN_B + 32'd1);
            e = exp_q.pop_front(); n_tests++;
            if (q_dmem !== e) begin
                n_fail++; $display("FAIL glitch_edge%0d got=%h exp=%h", k, q_dmem, e);
            end
        end
    endtask

    task automatic test_w1c();
        wr_cycle(IN_B, 32'd2, rw);
        n_tests++;
        if (rw !== 1'b0) begin
            n_fail++; $display("FAIL w1c_ram_wren got=%b exp=0", rw);
        end
        exp_q.push_back(32'h1);
        rd_cycle(IN_B);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL w1c_clear got=%h exp=%h", q_dmem, e);
        end

        // Falling level must not set evt.
        button_in[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back((k == 7) ? 32'h0 : 32'h1);
            rd_cycle(IN_B);
            e = exp_q.pop_front(); n_tests++;
            if (q_dmem !== e) begin
                n_fail++; $display("FAIL fall_edge%0d got=%h exp=%h", k, q_dmem, e);
            end
        end

        // Channel 2 rises on the 6th edge; the W1C lands on that same edge.
        button_in[2] = 1'b1;
        repeat (5) rd_cycle(32'd9);
        wr_cycle(IN_B + 32'd2, 32'd2, rw);
        exp_q.push_back(32'h3);
        rd_cycle(IN_B + 32'd2);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL set_beats_w1c got=%h exp=%h", q_dmem, e);
        end

        wr_cycle(IN_B + 32'd2, 32'hFFFFFFFD, rw);
        exp_q.push_back(32'h3);
        rd_cycle(IN_B + 32'd2);
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL w1c_bit1_only got=%h exp=%h", q_dmem, e);
        end
    endtask

`ifdef MMIO_IRQ_EN
    task automatic test_irq();
        wr_cycle(IN_B + 32'(NI), 32'h2, rw);
        n_tests++;
        if (rw !== 1'b0) begin
            n_fail++; $display("FAIL mask_ram_wren got=%b exp=0", rw);
        end
        exp_q.push_back(32'h2);
        rd_cycle(IN_B + 32'(NI));
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL mask_readback got=%h exp=%h", q_dmem, e);
        end
        button_in[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            rd_cycle(32'd9);
            n_tests++;
            if (irq !== (k >= 7)) begin
                n_fail++; $display("FAIL irq_edge%0d got=%b exp=%b", k, irq, (k >= 7));
            end
        end
        wr_cycle(IN_B + 32'd1, 32'd2, rw);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_hold got=%b exp=1", irq);
        end
        rd_cycle(32'd9);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear got=%b exp=0", irq);
        end
    endtask
`endif

    task automatic test_boundary();
        wr_cycle(OUT_B + 32'(NO), 32'h1234, rw);
        n_tests++;
        if (rw !== 1'b1) begin
            n_fail++; $display("FAIL out_end_ram_wren got=%b exp=1", rw);
        end
        n_tests++;
        if (processor_out !== {32'h0BADF00D, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            n_fail++; $display("FAIL out_end_unchanged got=%h", processor_out);
        end
        exp_q.push_back(32'hA5A507D4);
        rd_cycle(OUT_B + 32'(NO));
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL out_end_read got=%h exp=%h", q_dmem, e);
        end

        wr_cycle(OUT_B - 32'd1, 32'h55, rw);
        n_tests++;
        if (rw !== 1'b1) begin
            n_fail++; $display("FAIL out_below_ram_wren got=%b exp=1", rw);
        end

        wr_cycle(IN_B + 32'(NI), 32'h0, rw);
        n_tests++;
`ifdef MMIO_IRQ_EN
        if (rw !== 1'b0) begin
            n_fail++; $display("FAIL in_end_ram_wren got=%b exp=0", rw);
        end
`else
        if (rw !== 1'b1) begin
            n_fail++; $display("FAIL in_end_ram_wren got=%b exp=1", rw);
        end
        exp_q.push_back(32'hA5A503EC);
        rd_cycle(IN_B + 32'(NI));
        e = exp_q.pop_front(); n_tests++;
        if (q_dmem !== e) begin
            n_fail++; $display("FAIL in_end_read got=%h exp=%h", q_dmem, e);
        end
`endif
    endtask

    task automatic test_reset_priority();
        address_dmem = OUT_B + 32'd1;
        data = 32'h77;
        wren = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wren = 1'b0;
        n_tests++;
        if (processor_out !== '0) begin
            n_fail++; $display("FAIL reset_beats_write got=%h exp=0", processor_out);
        end

        // Reset after three cycles of debounce must restart the full latency.
        button_in[3] = 1'b1;
        repeat (3) rd_cycle(32'd9);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back((k == 7) ? 32'h3 : 32'h0);
            rd_cycle(IN_B + 32'd3);
            e = exp_q.pop_front(); n_tests++;
            if (q_dmem !== e) begin
                n_fail++; $display("FAIL reset_mid_debounce_edge%0d got=%h exp=%h", k, q_dmem, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_debounce();
        test_w1c();
`ifdef MMIO_IRQ_EN
        test_irq();
`endif
        test_boundary();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
